controlador_necessidades: RTL



---
 rtl/controlador_necessidades.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/controlador_necessidades.sv
// Pet vitals tracker: saciedade/energia/alegria decay or recover once per tick according to estado.
// Optional low-level warning output is built only when ALERTA_EN is defined.
module controlador_necessidades #(
    parameter int TICK_DIV      = 25000000,
    parameter int LARG          = 4,
    parameter int NIVEL_MAX     = 15,
    parameter int GANHO         = 3,
    parameter int LIMIAR_ALERTA = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      estado,
    output logic            morreu,
    output logic [LARG-1:0] saciedade,
    output logic [LARG-1:0] energia,
    output logic [LARG-1:0] alegria,
    output logic            alerta
);

    localparam int             CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  ULTIMO = CW'(TICK_DIV - 1);
    localparam logic [LARG:0]  TETO   = (LARG+1)'(NIVEL_MAX);
    localparam logic [LARG:0]  INC    = (LARG+1)'(GANHO);
    localparam logic [LARG-1:0] CHEIO = LARG'(NIVEL_MAX);

    localparam logic [3:0] COD_DORMINDO   = 4'b0001;
    localparam logic [3:0] COD_COMENDO    = 4'b0010;
    localparam logic [3:0] COD_DANDO_AULA = 4'b0100;
    localparam logic [3:0] COD_MORTO      = 4'b1000;

    typedef enum logic {VIVO, MORTO_INT} fase_t;

    fase_t           fase_q, fase_d;
    logic [CW-1:0]   contador_q, contador_d;
    logic [LARG-1:0] saciedade_q, saciedade_d;
    logic [LARG-1:0] energia_q, energia_d;
    logic [LARG-1:0] alegria_q, alegria_d;

    logic            tick;
    logic            ganhaSac, ganhaEn, ganhaAle;
    logic [1:0]      perdaSac, perdaEn, perdaAle;
    logic [LARG-1:0] novoSac, novoEn, novoAle;
    logic            morre;

    // Saturating update: never wraps past 0 nor above NIVEL_MAX.
    function automatic logic [LARG-1:0] ajusta(input logic [LARG-1:0] nivel,
                                               input logic            ganha,
                                               input logic [1:0]      perda);
        logic [LARG:0] largo;
        logic [LARG:0] sub;
        largo = {1'b0, nivel};
        sub   = (LARG+1)'(perda);
        if (ganha) begin
            largo = largo + INC;
        end else if (largo >= sub) begin
            largo = largo - sub;
        end else begin
            largo = '0;
        end
        if (largo > TETO) begin
            largo = TETO;
        end
        return largo[LARG-1:0];
    endfunction

    assign tick = (contador_q == ULTIMO);

    always_comb begin
        ganhaSac = 1'b0;
        ganhaEn  = 1'b0;
        ganhaAle = 1'b0;
        perdaSac = 2'd1;
        perdaEn  = 2'd1;
        perdaAle = 2'd1;
        case (estado)
            COD_COMENDO: begin
                ganhaSac = 1'b1;
                perdaSac = 2'd0;
            end
            COD_DORMINDO: begin
                ganhaEn = 1'b1;
                perdaEn = 2'd0;
            end
            COD_DANDO_AULA: begin
                perdaEn  = 2'd2;
                ganhaAle = 1'b1;
                perdaAle = 2'd0;
            end
            COD_MORTO: begin
                perdaSac = 2'd0;
                perdaEn  = 2'd0;
                perdaAle = 2'd0;
            end
            default: begin
            end
        endcase
    end

    assign novoSac = ajusta(saciedade_q, ganhaSac, perdaSac);
    assign novoEn  = ajusta(energia_q, ganhaEn, perdaEn);
    assign novoAle = ajusta(alegria_q, ganhaAle, perdaAle);
    assign morre   = (novoSac == '0) || (novoEn == '0) || (novoAle == '0);

    always_comb begin
        fase_d      = fase_q;
        saciedade_d = saciedade_q;
        energia_d   = energia_q;
        alegria_d   = alegria_q;
        contador_d  = tick ? '0 : contador_q + CW'(1);
        if (fase_q == VIVO && tick) begin
            saciedade_d = novoSac;
            energia_d   = novoEn;
            alegria_d   = novoAle;
            if (morre) begin
                fase_d = MORTO_INT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fase_q      <= VIVO;
            contador_q  <= '0;
            saciedade_q <= CHEIO;
            energia_q   <= CHEIO;
            alegria_q   <= CHEIO;
        end else begin
            fase_q      <= fase_d;
            contador_q  <= contador_d;
            saciedade_q <= saciedade_d;
            energia_q   <= energia_d;
            alegria_q   <= alegria_d;
        end
    end

`ifdef ALERTA_EN
    localparam logic [LARG-1:0] LIMIAR = LARG'(LIMIAR_ALERTA);

    logic alerta_q, alerta_d;

    // Alert follows the freshly computed levels, and is dropped on the edge that kills the pet.
    always_comb begin
        alerta_d = alerta_q;
        if (fase_q == VIVO && tick) begin
            alerta_d = !morre && ((novoSac <= LIMIAR) || (novoEn <= LIMIAR) || (novoAle <= LIMIAR));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alerta_q <= 1'b0;
        end else begin
            alerta_q <= alerta_d;
        end
    end

    assign alerta = alerta_q;
`else
    logic unused_limiar;
    assign unused_limiar = (LIMIAR_ALERTA != 0);
    assign alerta        = 1'b0;
`endif

    assign morreu    = (fase_q == MORTO_INT);
    assign saciedade = saciedade_q;
    assign energia   = energia_q;
    assign alegria   = alegria_q;

endmodule
